// File: rtl/icache_assoc.sv
// icache_assoc: N-way set-associative instruction cache with round-robin
// replacement, single outstanding block refill, flush and hit-under-miss.
//
// state | meaning
// IDLE  | no refill outstanding; a non-flush miss launches a block request
// WAIT  | request outstanding; lookups continue, fill installs victim way
module icache_assoc #(
  parameter int ADDR_W    = 32,
  parameter int WAYS      = 2,
  parameter int SETS      = 16,
  parameter int BLK_INSTR = 4
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    flush_in,
  input  logic                    if_valid,
  input  logic [ADDR_W-1:0]       if_ain,
  output logic                    miss,
  output logic                    if_out_en,
  output logic [31:0]             if_instr_out,
  output logic                    mem_req_en,
  output logic [ADDR_W-1:0]       mem_req_addr,
  input  logic                    mem_in_en,
  input  logic [32*BLK_INSTR-1:0] mem_din
);

  localparam int WRD_W = $clog2(BLK_INSTR);
  localparam int OFF_W = WRD_W + 2;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int BLK_W = 32 * BLK_INSTR;
  // rr pointer keeps one bit even for a direct-mapped build; it stays 0 there
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_launch;
  logic               w_fill;

  logic [WAYS-1:0]    r_valid [SETS];
  logic [TAG_W-1:0]   r_tag   [SETS][WAYS];
  logic [BLK_W-1:0]   r_data  [SETS][WAYS];
  logic [WAY_W-1:0]   r_rr    [SETS];

  logic [ADDR_W-1:0]  r_req_addr;
  logic [WAY_W-1:0]   r_victim;

  logic [TAG_W-1:0]   w_tag;
  logic [IDX_W-1:0]   w_idx;
  logic [WRD_W-1:0]   w_word;
  logic [TAG_W-1:0]   w_fill_tag;
  logic [IDX_W-1:0]   w_fill_idx;
  logic               w_hit;
  logic [BLK_W-1:0]   w_hit_blk;
  logic [WAY_W-1:0]   w_victim;
  logic               w_found;
  logic               w_unused_bits;

  assign w_tag         = if_ain[ADDR_W-1 -: TAG_W];
  assign w_idx         = if_ain[OFF_W +: IDX_W];
  assign w_word        = if_ain[2 +: WRD_W];
  assign w_unused_bits = ^if_ain[1:0];

  assign w_fill_tag    = r_req_addr[ADDR_W-1 -: TAG_W];
  assign w_fill_idx    = r_req_addr[OFF_W +: IDX_W];

  // Tag compare across all ways of the addressed set; at most one can match
  always_comb begin
    w_hit     = 1'b0;
    w_hit_blk = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_blk = r_data[w_idx][w];
      end
    end
  end

  assign miss         = if_valid & ~w_hit;
  assign if_out_en    = if_valid & w_hit;
  assign if_instr_out = if_out_en ? w_hit_blk[{w_word, 5'b00000} +: 32] : 32'h0;

  // Victim: lowest-index invalid way, otherwise the set's round-robin pointer
  always_comb begin
    w_victim = r_rr[w_idx];
    w_found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_found && !r_valid[w_idx][w]) begin
        w_found  = 1'b1;
        w_victim = WAY_W'(w);
      end
    end
  end

  // Refill FSM state register
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Refill FSM next state; flush always wins over launch and fill
  always_comb begin
    w_next   = r_state;
    w_launch = 1'b0;
    w_fill   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!flush_in && miss) begin
          w_launch = 1'b1;
          w_next   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush_in) begin
          w_next = ST_IDLE;
        end else if (mem_in_en) begin
          w_fill = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign mem_req_en   = (r_state == ST_WAIT);
  assign mem_req_addr = r_req_addr;

  // Capture block-aligned request address and victim way at launch
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_req_addr <= '0;
      r_victim   <= '0;
    end else if (w_launch) begin
      r_req_addr <= {if_ain[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      r_victim   <= w_victim;
    end
  end

  // Valid bits and round-robin pointers; pointer advances only on eviction
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else if (flush_in) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else if (w_fill) begin
      r_valid[w_fill_idx][r_victim] <= 1'b1;
      if ((WAYS > 1) && r_valid[w_fill_idx][r_victim])
        r_rr[w_fill_idx] <= WAY_W'(r_rr[w_fill_idx] + 1'b1);
    end
  end

  // Tag and data arrays, written only by accepted fills
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fill_idx][r_victim]  <= w_fill_tag;
      r_data[w_fill_idx][r_victim] <= mem_din;
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc at default parameters (2-way, 16 sets,
// 4 instructions per block). Fill blocks carry 0xC0DE0000 | byte address.
module tb_icache_assoc;

  logic         clk;
  logic         rst_in;
  logic         flush_in;
  logic         if_valid;
  logic [31:0]  if_ain;
  logic         miss;
  logic         if_out_en;
  logic [31:0]  if_instr_out;
  logic         mem_req_en;
  logic [31:0]  mem_req_addr;
  logic         mem_in_en;
  logic [127:0] mem_din;

  int n_cmp = 0;
  int n_err = 0;

  icache_assoc dut (
    .clk          (clk),
    .rst_in       (rst_in),
    .flush_in     (flush_in),
    .if_valid     (if_valid),
    .if_ain       (if_ain),
    .miss         (miss),
    .if_out_en    (if_out_en),
    .if_instr_out (if_instr_out),
    .mem_req_en   (mem_req_en),
    .mem_req_addr (mem_req_addr),
    .mem_in_en    (mem_in_en),
    .mem_din      (mem_din)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] blk_of(input logic [31:0] a);
    logic [127:0] b;
    logic [31:0]  base;
    base = a & 32'hFFFF_FFF0;
    for (int i = 0; i < 4; i++) b[32*i +: 32] = 32'hC0DE_0000 | (base + 32'(4*i));
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_valid = 1'b0;
    step();
  endtask

  task automatic look(input string tag, input logic [31:0] a, input logic h);
    if_valid = 1'b1;
    if_ain   = a;
    #1;
    chk({tag, "_hit"},   {31'b0, if_out_en}, {31'b0, h});
    chk({tag, "_miss"},  {31'b0, miss},      {31'b0, ~h});
    chk({tag, "_instr"}, if_instr_out,       h ? (32'hC0DE_0000 | a) : 32'h0);
  endtask

  // Miss from IDLE, then fill on the following edge
  task automatic load(input logic [31:0] a);
    if_valid  = 1'b1;
    if_ain    = a;
    step();
    mem_in_en = 1'b1;
    mem_din   = blk_of(a);
    step();
    mem_in_en = 1'b0;
    if_valid  = 1'b0;
  endtask

  initial begin
    rst_in    = 1'b0;
    flush_in  = 1'b0;
    if_valid  = 1'b0;
    if_ain    = 32'h0;
    mem_in_en = 1'b0;
    mem_din   = '0;
    #3;
    chk("rst_req_en",   {31'b0, mem_req_en}, 32'h0);
    chk("rst_req_addr", mem_req_addr,        32'h0);
    chk("rst_out_en",   {31'b0, if_out_en},  32'h0);
    step();
    step();
    rst_in = 1'b1;
    step();

    // Cold miss and fill
    if_valid = 1'b1;
    if_ain   = 32'h104;
    #1;
    chk("cold_miss",    {31'b0, miss},       32'h1);
    chk("cold_out_en",  {31'b0, if_out_en},  32'h0);
    chk("cold_req0",    {31'b0, mem_req_en}, 32'h0);
    step();
    chk("cold_req_en",   {31'b0, mem_req_en}, 32'h1);
    chk("cold_req_addr", mem_req_addr,        32'h100);
    mem_in_en = 1'b1;
    mem_din   = {32'h0, 32'h0, 32'h0000_0013, 32'h0};
    #1;
    chk("cold_same_cyc_miss", {31'b0, miss}, 32'h1);
    step();
    mem_in_en = 1'b0;
    #1;
    chk("cold_hit",    {31'b0, if_out_en},  32'h1);
    chk("cold_instr",  if_instr_out,        32'h0000_0013);
    chk("cold_req_dn", {31'b0, mem_req_en}, 32'h0);

    // Clear the cold line so replacement starts from an empty set
    if_valid = 1'b0;
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;

    // Replacement in set 0
    load(32'h000);
    load(32'h100);
    look("rep_a0", 32'h000, 1'b1);
    look("rep_a1", 32'h108, 1'b1);
    idle();
    load(32'h200);
    look("rep_b0", 32'h000, 1'b0);
    look("rep_b1", 32'h104, 1'b1);
    look("rep_b2", 32'h20C, 1'b1);
    idle();
    load(32'h300);
    look("rep_c0", 32'h100, 1'b0);
    look("rep_c1", 32'h200, 1'b1);
    look("rep_c2", 32'h304, 1'b1);
    idle();

    // Flush with a missing fetch on the flush edge
    if_valid = 1'b1;
    if_ain   = 32'h600;
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    chk("flush_no_req", {31'b0, mem_req_en}, 32'h0);
    look("flush_a", 32'h200, 1'b0);
    look("flush_b", 32'h300, 1'b0);
    idle();

    // Flush colliding with fill
    if_valid = 1'b1;
    if_ain   = 32'h400;
    step();
    chk("col_req_en",   {31'b0, mem_req_en}, 32'h1);
    chk("col_req_addr", mem_req_addr,        32'h400);
    flush_in  = 1'b1;
    mem_in_en = 1'b1;
    mem_din   = blk_of(32'h400);
    step();
    flush_in  = 1'b0;
    mem_in_en = 1'b0;
    chk("col_drop_req", {31'b0, mem_req_en}, 32'h0);
    chk("col_not_inst", {31'b0, miss},       32'h1);
    step();
    chk("col_rereq_en",   {31'b0, mem_req_en}, 32'h1);
    chk("col_rereq_addr", mem_req_addr,        32'h400);
    mem_in_en = 1'b1;
    mem_din   = blk_of(32'h400);
    step();
    mem_in_en = 1'b0;
    look("col_fill", 32'h404, 1'b1);
    chk("col_idle", {31'b0, mem_req_en}, 32'h0);
    if_valid = 1'b0;

    // Fill strobe while IDLE must not touch storage
    mem_in_en = 1'b1;
    mem_din   = {4{32'hDEAD_BEEF}};
    step();
    mem_in_en = 1'b0;
    look("idle_fill", 32'h408, 1'b1);
    idle();

    // Redirect during refill, with hit-under-miss
    if_valid = 1'b1;
    if_ain   = 32'h300;
    step();
    look("hum", 32'h404, 1'b1);
    if_ain = 32'h500;
    #1;
    chk("redir_miss", {31'b0, miss}, 32'h1);
    step();
    chk("redir_hold_en",   {31'b0, mem_req_en}, 32'h1);
    chk("redir_hold_addr", mem_req_addr,        32'h300);
    mem_in_en = 1'b1;
    mem_din   = blk_of(32'h300);
    step();
    mem_in_en = 1'b0;
    chk("redir_idle", {31'b0, mem_req_en}, 32'h0);
    step();
    chk("redir_new_en",   {31'b0, mem_req_en}, 32'h1);
    chk("redir_new_addr", mem_req_addr,        32'h500);
    look("redir_old", 32'h308, 1'b1);
    mem_in_en = 1'b1;
    mem_din   = blk_of(32'h500);
    step();
    mem_in_en = 1'b0;
    look("redir_fill", 32'h50C, 1'b1);
    idle();

    // Asynchronous reset mid-refill
    if_valid = 1'b1;
    if_ain   = 32'h610;
    step();
    chk("ar_req_en",   {31'b0, mem_req_en}, 32'h1);
    chk("ar_req_addr", mem_req_addr,        32'h610);
    #4;
    rst_in = 1'b0;
    #1;
    chk("ar_drop_en",   {31'b0, mem_req_en}, 32'h0);
    chk("ar_drop_addr", mem_req_addr,        32'h0);
    if_valid = 1'b0;
    step();
    rst_in = 1'b1;
    look("ar_a", 32'h504, 1'b0);
    look("ar_b", 32'h300, 1'b0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised N-way set-associative instruction cache; successor to the direct-mapped iCache, sitting between IF and the memory controller.
- Hit lookup is combinational in the same cycle.
- Misses are handled by an internal refill FSM that issues block requests to memory.
- Adds round-robin replacement, a fence.i-style flush, and hit-under-miss.

Parameters:
- ADDR_W, 32, address width.
- WAYS, 2, associativity; power of 2, 1..8.
- SETS, 16, number of sets; power of 2 ≥ 2.
- BLK_INSTR, 4, 32-bit instructions per block; power of 2 ≥ 2.
- Derived: OFF_W = log2(BLK_INSTR) + 2; IDX_W = log2(SETS); TAG_W = ADDR_W − IDX_W − OFF_W; BLK_W = 32·BLK_INSTR.

Ports:
- clk  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset.
- flush_in  in  1  invalidate all lines (one-cycle pulse).
- if_valid  in  1  IF presents a fetch address.
- if_ain  in  ADDR_W  fetch address.
- miss  out  1  if_valid && !hit.
- if_out_en  out  1  if_valid && hit.
- if_instr_out  out  32  addressed instruction on hit, else 0.
- mem_req_en  out  1  block refill request, held until fill.
- mem_req_addr  out  ADDR_W  block-aligned refill address (low OFF_W bits 0).
- mem_in_en  in  1  fill data valid (one cycle).
- mem_din  in  BLK_W  fill block; instruction i at bits [32i+31:32i].

Behaviour:
- Address split: tag = if_ain[ADDR_W−1 : IDX_W+OFF_W]; idx = next IDX_W bits; word = if_ain[OFF_W−1:2]; bits [1:0] ignored.
- Storage: per way/set: valid, tag, data. Per set: round-robin pointer rr of log2(WAYS) bits (0-width when WAYS=1, victim always way 0).
- Hit: any way in set idx valid with matching tag. At most one way can match, because a fill never targets a set already holding that tag. Outputs are purely combinational from current state.
- Reset (rst_in=0, asynchronous): all valid=0, all rr=0, FSM=IDLE, mem_req_en=0, mem_req_addr=0. Tag/data storage need not be cleared. Combinational outputs follow (if_out_en=0).
- FSM states:
  - IDLE: on a clock edge with miss=1 and flush_in=0, capture the block-aligned if_ain into mem_req_addr and the victim way, then go to WAIT. mem_req_en rises the cycle after miss is first seen.
  - WAIT: mem_req_en=1, mem_req_addr stable. On a clock edge with mem_in_en=1, write valid=1, tag and data into the victim way. If the victim was valid beforehand, rr[set] increments mod WAYS. Return to IDLE. A hit on the filled address appears the cycle after mem_in_en.
- Victim selection (at capture): lowest-index invalid way in the set, else rr[set].
- Hit-under-miss: lookups continue during WAIT; hits to other lines are served normally.
- New misses during WAIT: miss=1 is reported but no second request is launched.
- IF redirect during WAIT: the refill still completes and is installed. A still-missing new address launches its request from IDLE on the next edge.
- mem_in_en while IDLE: ignored.
- flush_in=1 on an edge: all valid=0 and rr=0.
  - If in WAIT, the refill is abandoned: FSM goes to IDLE, mem_req_en drops, and any mem_in_en arriving that same edge is discarded (flush wins).
  - No request is launched on a flush edge.
  - Memory must tolerate a dropped request. A late fill arriving while IDLE is ignored, per the rule above.
- Simultaneous fill and lookup of the same block: lookup in that cycle still misses; it hits the next cycle.
- Storage is written only by fills; there is no write-through or self-modifying-code path other than flush.

Test Plan:
- Defaults (2-way, 16 sets, 4 instr/block; idx=[7:4], tag=[31:8]).
- Cold miss and fill:
  - Stimulus: after reset, if_valid=1, if_ain=0x104.
  - Response: miss=1 and if_out_en=0; next cycle mem_req_en=1 and mem_req_addr=0x100.
  - Then mem_in_en=1 with mem_din[63:32]=0x00000013. The cycle after: if_out_en=1, if_instr_out=0x00000013.
- Replacement:
  - Stimulus: fill 0x000 then 0x100 (both set 0); both hit.
  - Then miss 0x200. Response: way0 is evicted (rr=0); 0x000 misses, 0x100 and 0x200 hit, rr[0]=1.
  - Then miss 0x300. Response: 0x100 is evicted.
- Flush:
  - Stimulus: with 0x000 and 0x100 resident, pulse flush_in.
  - Response: next cycle both miss, and no request was issued on the flush edge.
- Flush colliding with fill:
  - Stimulus: in WAIT for 0x400, assert flush_in and mem_in_en on the same edge.
  - Response: FSM goes to IDLE, 0x400 is not installed, and mem_req_en re-asserts for 0x400 one cycle later (if_ain unchanged).
- Redirect during refill:
  - Stimulus: WAIT on 0x300, if_ain switches to 0x500.
  - Response: mem_req_addr stays 0x300 until the fill. The cycle after the fill, mem_req_addr=0x500 with mem_req_en=1, and 0x300 hits when re-fetched.
- Asynchronous reset mid-refill:
  - Stimulus: drive rst_in low between edges while in WAIT.
  - Response: mem_req_en=0 immediately, without waiting for a clock edge. After release, previously resident lines miss.
